// File: rtl/fb_mem_arbiter.sv
// Framebuffer memory arbiter: one Avalon-MM port shared by the pixel scan-out reader (priority,
// starvation-bounded) and NUM_CORES round-robin core masters, with in-order read return routing.
module fb_mem_arbiter #(
  parameter int unsigned NUM_CORES    = 6,
  parameter int unsigned ADDR_W       = 24,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned MAX_PENDING  = 8,
  parameter int unsigned PX_BURST_MAX = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [ADDR_W-1:0]                 px_address,
  input  logic                              px_read,
  output logic                              px_waitrequest,
  output logic [DATA_W-1:0]                 px_readdata,
  output logic                              px_readdatavalid,
  input  logic [NUM_CORES*ADDR_W-1:0]       c_address,
  input  logic [NUM_CORES-1:0]              c_read,
  input  logic [NUM_CORES-1:0]              c_write,
  input  logic [NUM_CORES*DATA_W-1:0]       c_writedata,
  input  logic [NUM_CORES*(DATA_W/8)-1:0]   c_byteenable,
  output logic [NUM_CORES-1:0]              c_waitrequest,
  output logic [DATA_W-1:0]                 c_readdata,
  output logic [NUM_CORES-1:0]              c_readdatavalid,
  output logic [ADDR_W-1:0]                 m_address,
  output logic                              m_read,
  output logic                              m_write,
  output logic [DATA_W-1:0]                 m_writedata,
  output logic [DATA_W/8-1:0]               m_byteenable,
  input  logic                              m_waitrequest,
  input  logic [DATA_W-1:0]                 m_readdata,
  input  logic                              m_readdatavalid,
  output logic                              err_orphan,
  output logic [$clog2(MAX_PENDING):0]      pending
);

  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned ID_W   = $clog2(NUM_CORES + 1);
  localparam int unsigned PTR_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int unsigned CNT_W  = $clog2(PX_BURST_MAX + 1);
  localparam int unsigned PEND_W = $clog2(MAX_PENDING) + 1;
  localparam int unsigned FA_W   = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam logic [ID_W-1:0] PxId = ID_W'(NUM_CORES);

  typedef enum logic [0:0] {StUnlocked, StLocked} lock_e;

  lock_e             state_q, state_d;
  logic [ID_W-1:0]   lock_id_q, lock_id_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  burst_q, burst_d;
  logic [PEND_W-1:0] cnt_q, cnt_d;
  logic [FA_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [ID_W-1:0]   tag_mem_q [2**FA_W];
  logic              err_q;

  logic                 rd_ok, px_elig, rr_found, gnt_valid;
  logic [NUM_CORES-1:0] core_elig;
  logic [PTR_W-1:0]     rr_idx;
  logic [ID_W-1:0]      rr_id, gnt_id, head_id;
  logic                 accept, core_acc, px_acc, push, pop, orphan;

  // A full FIFO still admits a read in the cycle a return frees a slot.
  assign rd_ok     = (cnt_q != PEND_W'(MAX_PENDING)) || m_readdatavalid;
  assign core_elig = c_write | (c_read & {NUM_CORES{rd_ok}});
  assign px_elig   = px_read & rd_ok;

  always_comb begin
    rr_found = 1'b0;
    rr_id    = '0;
    rr_idx   = '0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      rr_idx = PTR_W'((32'(ptr_q) + k) % NUM_CORES);
      if (!rr_found && core_elig[rr_idx]) begin
        rr_found = 1'b1;
        rr_id    = ID_W'(rr_idx);
      end
    end
  end

  // Grant (FSM output logic).
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = '0;
    if (!reset) begin
      case (state_q)
        StLocked: begin
          gnt_valid = 1'b1;
          gnt_id    = lock_id_q;
        end
        default: begin
          if (px_elig && (burst_q < CNT_W'(PX_BURST_MAX))) begin
            gnt_valid = 1'b1;
            gnt_id    = PxId;
          end else if (rr_found) begin
            gnt_valid = 1'b1;
            gnt_id    = rr_id;
          end else if (px_elig) begin
            gnt_valid = 1'b1;
            gnt_id    = PxId;
          end
        end
      endcase
    end
  end

  always_comb begin
    m_address      = '0;
    m_read         = 1'b0;
    m_write        = 1'b0;
    m_writedata    = '0;
    m_byteenable   = '1;
    px_waitrequest = 1'b1;
    c_waitrequest  = '1;
    if (gnt_valid) begin
      if (gnt_id == PxId) begin
        m_address      = px_address;
        m_read         = px_read;
        px_waitrequest = m_waitrequest;
      end else begin
        for (int unsigned i = 0; i < NUM_CORES; i++) begin
          if (gnt_id == ID_W'(i)) begin
            m_address        = c_address[i*ADDR_W +: ADDR_W];
            m_read           = c_read[i];
            m_write          = c_write[i];
            m_writedata      = c_writedata[i*DATA_W +: DATA_W];
            m_byteenable     = c_byteenable[i*BE_W +: BE_W];
            c_waitrequest[i] = m_waitrequest;
          end
        end
      end
    end
  end

  assign accept   = (m_read | m_write) & ~m_waitrequest;
  assign core_acc = accept && (gnt_id != PxId);
  assign px_acc   = accept && (gnt_id == PxId);

  always_comb begin
    state_d   = state_q;
    lock_id_d = lock_id_q;
    case (state_q)
      StUnlocked: begin
        if ((m_read | m_write) && m_waitrequest) begin
          state_d   = StLocked;
          lock_id_d = gnt_id;
        end
      end
      StLocked: if (accept) state_d = StUnlocked;
      default:  state_d = StUnlocked;
    endcase
  end

  always_comb begin
    ptr_d   = ptr_q;
    burst_d = burst_q;
    if (core_acc) begin
      ptr_d = (gnt_id == ID_W'(NUM_CORES - 1)) ? '0 : PTR_W'(gnt_id) + 1'b1;
    end
    if (!px_read || core_acc) begin
      burst_d = '0;
    end else if (px_acc && (burst_q != CNT_W'(PX_BURST_MAX))) begin
      burst_d = burst_q + 1'b1;
    end
  end

  assign push    = accept & m_read;
  assign pop     = m_readdatavalid & (cnt_q != '0);
  assign orphan  = m_readdatavalid & (cnt_q == '0);
  assign head_id = tag_mem_q[rd_ptr_q];
  assign cnt_d   = cnt_q + PEND_W'(push) - PEND_W'(pop);

  always_comb begin
    c_readdatavalid  = '0;
    px_readdatavalid = !reset && pop && (head_id == PxId);
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      c_readdatavalid[i] = !reset && pop && (head_id == ID_W'(i));
    end
  end

  assign px_readdata = m_readdata;
  assign c_readdata  = m_readdata;
  assign err_orphan  = err_q;
  assign pending     = cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StUnlocked;
      lock_id_q <= '0;
      ptr_q     <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_id_q <= lock_id_d;
      ptr_q     <= ptr_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      if (push)   wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
      if (orphan) err_q    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) tag_mem_q[wr_ptr_q] <= gnt_id;
  end

endmodule

// File: tb/tb_fb_mem_arbiter.sv
// Directed bench for fb_mem_arbiter: grant/lock/FIFO checks with a tag scoreboard for returns.
module tb_fb_mem_arbiter;

  localparam int NC   = 6;
  localparam int AW   = 24;
  localparam int DW   = 32;
  localparam int BEW  = DW / 8;
  localparam int MAXP = 8;

  logic              clk, reset;
  logic [AW-1:0]     px_address;
  logic              px_read, px_waitrequest, px_readdatavalid;
  logic [DW-1:0]     px_readdata;
  logic [NC*AW-1:0]  c_address;
  logic [NC-1:0]     c_read, c_write, c_waitrequest, c_readdatavalid;
  logic [NC*DW-1:0]  c_writedata;
  logic [NC*BEW-1:0] c_byteenable;
  logic [DW-1:0]     c_readdata;
  logic [AW-1:0]     m_address;
  logic              m_read, m_write, m_waitrequest, m_readdatavalid;
  logic [DW-1:0]     m_writedata, m_readdata;
  logic [BEW-1:0]    m_byteenable;
  logic              err_orphan;
  logic [$clog2(MAXP):0] pending;

  fb_mem_arbiter #(
    .NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .MAX_PENDING(MAXP), .PX_BURST_MAX(16)
  ) dut (
    .clk(clk), .reset(reset),
    .px_address(px_address), .px_read(px_read), .px_waitrequest(px_waitrequest),
    .px_readdata(px_readdata), .px_readdatavalid(px_readdatavalid),
    .c_address(c_address), .c_read(c_read), .c_write(c_write), .c_writedata(c_writedata),
    .c_byteenable(c_byteenable), .c_waitrequest(c_waitrequest), .c_readdata(c_readdata),
    .c_readdatavalid(c_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write), .m_writedata(m_writedata),
    .m_byteenable(m_byteenable), .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid),
    .err_orphan(err_orphan), .pending(pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int exp_q[$];
  logic exp_err;
  int rr_ord[6] = '{0, 3, 5, 0, 3, 5};

  function automatic logic [AW-1:0] exp_addr(input int id);
    if (id == NC) return 24'h200000;
    if (id == 2) return 24'h000100;
    return 24'h001000 + AW'(id);
  endfunction

  function automatic logic [DW-1:0] exp_wd(input int id);
    return 32'hA000_0000 + DW'(id) * 32'h0101_0101;
  endfunction

  function automatic logic [BEW-1:0] exp_be(input int id);
    return BEW'(id + 1);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive the return, check combinational outputs, then cross the edge.
  task automatic step(input string tag, input int id, input logic rd, input logic wr,
                      input logic do_ret, input logic [DW-1:0] rdata);
    logic [NC-1:0] exp_cw, exp_cv;
    logic          exp_pw, exp_pv, orph;
    int            e;
    m_readdatavalid = do_ret;
    m_readdata      = rdata;
    #1;
    chk({tag, "/pending"}, 64'(pending), 64'(exp_q.size()));
    chk({tag, "/err"}, 64'(err_orphan), 64'(exp_err));
    chk({tag, "/m_read"}, 64'(m_read), 64'(rd));
    chk({tag, "/m_write"}, 64'(m_write), 64'(wr));
    if (rd || wr) chk({tag, "/m_address"}, 64'(m_address), 64'(exp_addr(id)));
    if (wr) begin
      chk({tag, "/m_writedata"}, 64'(m_writedata), 64'(exp_wd(id)));
      chk({tag, "/m_byteenable"}, 64'(m_byteenable), 64'(exp_be(id)));
    end
    exp_cw = '1;
    exp_pw = 1'b1;
    if ((rd || wr) && id == NC) exp_pw = m_waitrequest;
    if ((rd || wr) && id < NC) begin
      exp_cw = ~(NC'(1) << id) | (m_waitrequest ? (NC'(1) << id) : '0);
    end
    chk({tag, "/c_waitrequest"}, 64'(c_waitrequest), 64'(exp_cw));
    chk({tag, "/px_waitrequest"}, 64'(px_waitrequest), 64'(exp_pw));
    exp_cv = '0;
    exp_pv = 1'b0;
    orph   = 1'b0;
    if (do_ret) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (e == NC) exp_pv = 1'b1;
        else exp_cv = NC'(1) << e;
      end else begin
        orph = 1'b1;
      end
      chk({tag, "/c_readdata"}, 64'(c_readdata), 64'(rdata));
      chk({tag, "/px_readdata"}, 64'(px_readdata), 64'(rdata));
    end
    chk({tag, "/c_readdatavalid"}, 64'(c_readdatavalid), 64'(exp_cv));
    chk({tag, "/px_readdatavalid"}, 64'(px_readdatavalid), 64'(exp_pv));
    if (rd && !m_waitrequest) exp_q.push_back(id);
    @(posedge clk);
    #1;
    m_readdatavalid = 1'b0;
    if (orph) exp_err = 1'b1;
  endtask

  task automatic cmd(input string tag, input int id, input logic rd, input logic wr,
                     input logic do_ret);
    step(tag, id, rd, wr, do_ret, $urandom);
  endtask

  task automatic idle(input string tag, input logic do_ret);
    step(tag, 0, 1'b0, 1'b0, do_ret, $urandom);
  endtask

  task automatic do_reset();
    reset           = 1'b1;
    px_read         = 1'b1;
    c_read          = '1;
    c_write         = '0;
    m_waitrequest   = 1'b0;
    m_readdatavalid = 1'b1;
    #1;
    chk("rst/m_read", 64'(m_read), 64'(0));
    chk("rst/m_write", 64'(m_write), 64'(0));
    chk("rst/c_waitrequest", 64'(c_waitrequest), 64'(6'h3f));
    chk("rst/px_waitrequest", 64'(px_waitrequest), 64'(1));
    chk("rst/c_readdatavalid", 64'(c_readdatavalid), 64'(0));
    chk("rst/px_readdatavalid", 64'(px_readdatavalid), 64'(0));
    @(posedge clk);
    #1;
    chk("rst/pending", 64'(pending), 64'(0));
    chk("rst/err_orphan", 64'(err_orphan), 64'(0));
    reset           = 1'b0;
    px_read         = 1'b0;
    c_read          = '0;
    m_readdatavalid = 1'b0;
    exp_q.delete();
    exp_err = 1'b0;
  endtask

  initial begin
    px_address = exp_addr(NC);
    m_readdata = '0;
    for (int i = 0; i < NC; i++) begin
      c_address[i*AW +: AW]     = exp_addr(i);
      c_writedata[i*DW +: DW]   = exp_wd(i);
      c_byteenable[i*BEW +: BEW] = exp_be(i);
    end
    do_reset();

    // Single core-2 read, returned two cycles later.
    c_read[2] = 1'b1;
    cmd("c2_rd", 2, 1'b1, 1'b0, 1'b0);
    c_read = '0;
    idle("c2_gap", 1'b0);
    step("c2_ret", 0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);
    idle("c2_after", 1'b0);

    // Round robin among cores 0, 3, 5.
    do_reset();
    c_read = 6'b101001;
    for (int k = 0; k < 6; k++) cmd("rr", rr_ord[k], 1'b1, 1'b0, 1'b0);
    c_read = '0;
    for (int k = 0; k < 6; k++) idle("rr_ret", 1'b1);

    // Pixel burst bound, then uninterrupted pixel reads once core 1 is idle.
    do_reset();
    px_read   = 1'b1;
    c_read[1] = 1'b1;
    for (int k = 0; k < 16; k++) cmd("px_burst", NC, 1'b1, 1'b0, k > 0);
    cmd("px_yield", 1, 1'b1, 1'b0, 1'b1);
    c_read = '0;
    for (int k = 0; k < 20; k++) cmd("px_sat", NC, 1'b1, 1'b0, 1'b1);
    px_read = 1'b0;
    idle("px_drain", 1'b1);

    // Core-4 write held through a 3-cycle stall while the pixel port starts requesting.
    do_reset();
    c_write[4]    = 1'b1;
    m_waitrequest = 1'b1;
    cmd("wstall0", 4, 1'b0, 1'b1, 1'b0);
    px_read = 1'b1;
    cmd("wstall1", 4, 1'b0, 1'b1, 1'b0);
    cmd("wstall2", 4, 1'b0, 1'b1, 1'b0);
    m_waitrequest = 1'b0;
    cmd("wacc", 4, 1'b0, 1'b1, 1'b0);
    c_write = '0;
    cmd("px_after_w", NC, 1'b1, 1'b0, 1'b0);
    px_read = 1'b0;
    idle("w_drain", 1'b1);

    // Tag FIFO full: reads blocked, writes pass, pop frees a slot in the same cycle.
    do_reset();
    c_read[0] = 1'b1;
    for (int k = 0; k < MAXP; k++) cmd("fill", 0, 1'b1, 1'b0, 1'b0);
    c_write[3] = 1'b1;
    cmd("full_wr", 3, 1'b0, 1'b1, 1'b0);
    c_write = '0;
    idle("full_stall", 1'b0);
    cmd("full_pop", 0, 1'b1, 1'b0, 1'b1);
    c_read = '0;
    for (int k = 0; k < MAXP; k++) idle("full_drain", 1'b1);

    // Reset with reads outstanding; the late return is an orphan.
    do_reset();
    c_read[5] = 1'b1;
    for (int k = 0; k < 3; k++) cmd("orph_fill", 5, 1'b1, 1'b0, 1'b0);
    c_read = '0;
    do_reset();
    idle("orph_ret", 1'b1);
    idle("orph_chk", 1'b0);
    idle("orph_sticky", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
